// File: rtl/sobel_row_serializer_pkg.sv
// sobel_row_serializer_pkg: default geometry and pixel/row types shared by the row serializer slice
package sobel_row_serializer_pkg;
    localparam int DEF_PIX_W = 8;
    localparam int DEF_SIZE = 100;
    localparam int DEF_OUT_W = DEF_SIZE - 2;
    typedef logic [DEF_PIX_W-1:0] pixel_t;
    typedef pixel_t row_t [DEF_OUT_W];
endpackage

// File: rtl/sobel_row_serializer_if.sv
// sobel_row_serializer_if: row push side (row_in/row_valid/row_ready) plus pixel stream side (m_*), slave = serializer
interface sobel_row_serializer_if
    import sobel_row_serializer_pkg::*;
#(
    parameter int PIX_W = DEF_PIX_W,
    parameter int OUT_W = DEF_OUT_W
);
    logic [PIX_W-1:0] row_in [OUT_W];
    logic row_valid, row_ready;
    logic [PIX_W-1:0] m_pixel;
    logic m_valid, m_ready, m_sol, m_eol, m_sof, m_eof;
    modport master (
        output row_in, row_valid, m_ready,
        input row_ready, m_pixel, m_valid, m_sol, m_eol, m_sof, m_eof
    );
    modport slave (
        input row_in, row_valid, m_ready,
        output row_ready, m_pixel, m_valid, m_sol, m_eol, m_sof, m_eof
    );
endinterface

// File: rtl/sobel_row_serializer_row_fifo.sv
// sobel_row_serializer_row_fifo: whole-row FIFO (clk, rst, push/wr_row in, pop in, rd_row/full/empty out), DEPTH power of 2
module sobel_row_serializer_row_fifo
    import sobel_row_serializer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PIX_W = DEF_PIX_W,
    parameter int OUT_W = DEF_OUT_W,
    localparam int PW = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  logic [PIX_W-1:0] wr_row [OUT_W],
    output logic [PIX_W-1:0] rd_row [OUT_W],
    output logic full,
    output logic empty
);
    logic [PIX_W-1:0] mem [DEPTH][OUT_W];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= wr_row;
    assign rd_row = mem[rd_ptr];
    assign full = count == CNT_W'(DEPTH);
    assign empty = count == '0;
endmodule

// File: rtl/sobel_row_serializer.sv
// sobel_row_serializer: buffers filtered rows and streams them one pixel per beat (clk, rst, bus slave, sticky overflow out)
module sobel_row_serializer
    import sobel_row_serializer_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int PIX_W = DEF_PIX_W,
    parameter int ROW_DEPTH = 2,
    localparam int OUT_W = SIZE - 2,
    localparam int CW = $clog2(OUT_W)
) (
    input  logic clk,
    input  logic rst,
    sobel_row_serializer_if.slave bus,
    output logic overflow
);
    logic full, empty, push, pop, beat, at_eol, at_last_row;
    logic [PIX_W-1:0] rd_row [OUT_W];
    logic [CW-1:0] col, row;
    assign at_eol = col == CW'(OUT_W - 1);
    assign at_last_row = row == CW'(OUT_W - 1);
    assign beat = bus.m_valid && bus.m_ready;
    assign push = bus.row_valid && !full;
    assign pop = beat && at_eol;
    sobel_row_serializer_row_fifo #(
        .DEPTH(ROW_DEPTH),
        .PIX_W(PIX_W),
        .OUT_W(OUT_W)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .wr_row(bus.row_in),
        .rd_row(rd_row),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            overflow <= 1'b0;
        end else begin
            if (bus.row_valid && full) overflow <= 1'b1;
            if (beat) col <= at_eol ? '0 : col + 1'b1;
            if (pop) row <= at_last_row ? '0 : row + 1'b1;
        end
    end
    assign bus.row_ready = !full;
    assign bus.m_valid = !empty;
    assign bus.m_pixel = bus.m_valid ? rd_row[col] : '0;
    assign bus.m_sol = bus.m_valid && col == '0;
    assign bus.m_eol = bus.m_valid && at_eol;
    assign bus.m_sof = bus.m_sol && row == '0;
    assign bus.m_eof = bus.m_eol && at_last_row;
endmodule

// File: tb/tb_sobel_row_serializer.sv
// tb_sobel_row_serializer: scoreboard bench for the row serializer at SIZE=5 (OUT_W=3), ROW_DEPTH=2
module tb_sobel_row_serializer;
    typedef struct packed {
        logic [7:0] pix;
        logic sol, eol, sof, eof;
    } beat_t;
    logic tb_clk = 1'b0;
    logic rst = 1'b1;
    logic overflow;
    int checks = 0;
    int errors = 0;
    int beats = 0;
    int mrow = 0;
    beat_t q[$];
    sobel_row_serializer_if #(.PIX_W(8), .OUT_W(3)) bus();
    sobel_row_serializer #(.SIZE(5), .PIX_W(8), .ROW_DEPTH(2)) dut (
        .clk(tb_clk),
        .rst(rst),
        .bus(bus.slave),
        .overflow(overflow)
    );
    always #5 tb_clk = ~tb_clk;

    always @(negedge tb_clk) begin
        beat_t got, want;
        if (!rst && bus.m_valid && bus.m_ready) begin
            got = {bus.m_pixel, bus.m_sol, bus.m_eol, bus.m_sof, bus.m_eof};
            beats++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL extra_beat got pix=%0d sol/eol/sof/eof=%b%b%b%b expected no beat",
                         got.pix, got.sol, got.eol, got.sof, got.eof);
            end else begin
                want = q.pop_front();
                if (got !== want) begin
                    errors++;
                    $display("FAIL beat got pix=%0d sol/eol/sof/eof=%b%b%b%b expected pix=%0d %b%b%b%b",
                             got.pix, got.sol, got.eol, got.sof, got.eof,
                             want.pix, want.sol, want.eol, want.sof, want.eof);
                end
            end
        end
    end

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic model_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] v [3];
        beat_t e;
        v = '{a, b, c};
        for (int i = 0; i < 3; i++) begin
            e.pix = v[i];
            e.sol = i == 0;
            e.eol = i == 2;
            e.sof = i == 0 && mrow == 0;
            e.eof = i == 2 && mrow == 2;
            q.push_back(e);
        end
        mrow = (mrow + 1) % 3;
    endtask

    task automatic push_row(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        int n = 0;
        while (bus.row_ready !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (bus.row_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_ready_wait got=%b expected=1", bus.row_ready);
        end
        bus.row_in[0] = a;
        bus.row_in[1] = b;
        bus.row_in[2] = c;
        bus.row_valid = 1'b1;
        model_row(a, b, c);
        step();
        bus.row_valid = 1'b0;
    endtask

    task automatic push_drop(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        bus.row_in[0] = a;
        bus.row_in[1] = b;
        bus.row_in[2] = c;
        bus.row_valid = 1'b1;
        checks++;
        if (bus.row_ready !== 1'b0) begin
            errors++;
            $display("FAIL drop_ready got=%b expected=0", bus.row_ready);
        end
        step();
        bus.row_valid = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set got=%b expected=1", overflow);
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (q.size() != 0 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain got=%0d pending expected=0", name, q.size());
        end
        checks++;
        if (bus.m_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got m_valid=%b expected=0", name, bus.m_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.row_valid = 1'b0;
        bus.m_ready = 1'b0;
        for (int i = 0; i < 3; i++) bus.row_in[i] = '0;
        step();
        step();
        q.delete();
        mrow = 0;
        rst = 1'b0;
        step();
        checks++;
        if ({bus.row_ready, bus.m_valid, bus.m_pixel, bus.m_sol, bus.m_eol, bus.m_sof, bus.m_eof, overflow}
            !== {1'b1, 1'b0, 8'd0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL reset got ready=%b valid=%b pix=%0d mk=%b%b%b%b ovf=%b expected ready=1 rest 0",
                     bus.row_ready, bus.m_valid, bus.m_pixel, bus.m_sol, bus.m_eol, bus.m_sof, bus.m_eof, overflow);
        end
    endtask

    task automatic test_single_row();
        bus.m_ready = 1'b1;
        push_row(8'd10, 8'd20, 8'd30);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_pixel !== 8'd10) begin
            errors++;
            $display("FAIL latency got valid=%b pix=%0d expected valid=1 pix=10", bus.m_valid, bus.m_pixel);
        end
        drain("single_row");
    endtask

    task automatic test_overflow();
        int b0;
        bus.m_ready = 1'b0;
        push_row(8'd41, 8'd42, 8'd43);
        push_row(8'd44, 8'd45, 8'd46);
        checks++;
        if (bus.row_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_ready got=%b expected=0", bus.row_ready);
        end
        push_drop(8'd47, 8'd48, 8'd49);
        b0 = beats;
        bus.m_ready = 1'b1;
        drain("overflow");
        checks++;
        if (beats - b0 != 6) begin
            errors++;
            $display("FAIL overflow_beats got=%0d expected=6", beats - b0);
        end
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky got=%b expected=1", overflow);
        end
    endtask

    task automatic test_stall();
        logic [12:0] snap;
        bus.m_ready = 1'b0;
        push_row(8'd7, 8'd8, 8'd9);
        for (int i = 0; i < 8; i++) begin
            bus.m_ready = (i % 2) == 0;
            @(negedge tb_clk);
            snap = {bus.m_valid, bus.m_pixel, bus.m_sol, bus.m_eol, bus.m_sof, bus.m_eof};
            step();
            if (!bus.m_ready) begin
                checks++;
                if ({bus.m_valid, bus.m_pixel, bus.m_sol, bus.m_eol, bus.m_sof, bus.m_eof} !== snap) begin
                    errors++;
                    $display("FAIL stall_hold got=%h expected=%h",
                             {bus.m_valid, bus.m_pixel, bus.m_sol, bus.m_eol, bus.m_sof, bus.m_eof}, snap);
                end
            end
        end
        bus.m_ready = 1'b1;
        drain("stall");
    endtask

    task automatic test_frame();
        test_reset();
        bus.m_ready = 1'b1;
        push_row(8'd1, 8'd2, 8'd3);
        push_row(8'd4, 8'd5, 8'd6);
        push_row(8'd7, 8'd8, 8'd9);
        drain("frame");
        push_row(8'd100, 8'd101, 8'd102);
        checks++;
        if (bus.m_sof !== 1'b1 || bus.m_pixel !== 8'd100) begin
            errors++;
            $display("FAIL next_frame_sof got sof=%b pix=%0d expected sof=1 pix=100", bus.m_sof, bus.m_pixel);
        end
        drain("next_frame");
    endtask

    task automatic test_back_to_back();
        bus.m_ready = 1'b1;
        push_row(8'd11, 8'd12, 8'd13);
        step();
        step();
        checks++;
        if (bus.m_eol !== 1'b1 || bus.m_pixel !== 8'd13) begin
            errors++;
            $display("FAIL b2b_eol got eol=%b pix=%0d expected eol=1 pix=13", bus.m_eol, bus.m_pixel);
        end
        push_row(8'd21, 8'd22, 8'd23);
        checks++;
        if (bus.m_valid !== 1'b1 || bus.m_sol !== 1'b1 || bus.m_pixel !== 8'd21) begin
            errors++;
            $display("FAIL b2b_next got valid=%b sol=%b pix=%0d expected 1 1 21", bus.m_valid, bus.m_sol, bus.m_pixel);
        end
        drain("b2b");
    endtask

    task automatic test_mid_reset();
        int b0;
        int n = 0;
        bus.m_ready = 1'b0;
        push_row(8'd31, 8'd32, 8'd33);
        push_row(8'd34, 8'd35, 8'd36);
        push_drop(8'd37, 8'd38, 8'd39);
        b0 = beats;
        bus.m_ready = 1'b1;
        while (beats - b0 < 4 && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (beats - b0 != 4) begin
            errors++;
            $display("FAIL mid_beats got=%0d expected=4", beats - b0);
        end
        rst = 1'b1;
        bus.m_ready = 1'b0;
        step();
        q.delete();
        mrow = 0;
        rst = 1'b0;
        checks++;
        if (bus.m_valid !== 1'b0 || overflow !== 1'b0 || bus.row_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset got valid=%b ovf=%b ready=%b expected 0 0 1", bus.m_valid, overflow, bus.row_ready);
        end
        bus.m_ready = 1'b1;
        push_row(8'd51, 8'd52, 8'd53);
        checks++;
        if (bus.m_sof !== 1'b1 || bus.m_pixel !== 8'd51) begin
            errors++;
            $display("FAIL post_reset_sof got sof=%b pix=%0d expected sof=1 pix=51", bus.m_sof, bus.m_pixel);
        end
        drain("post_reset");
    endtask

    initial begin
        test_reset();
        test_single_row();
        test_overflow();
        test_stall();
        test_frame();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
